// File: rtl/out_port_buffer.sv
// ============================================================================
// Module   : out_port_buffer
// Brief    : First-word-fall-through output FIFO with a sticky overflow flag.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module out_port_buffer #(
    parameter int DEPTH = 4
) (
    input  logic                     Clock,
    input  logic                     Clear,
    input  logic                     OutPort,
    input  logic [31:0]              BusMuxOut,
    output logic [31:0]              Out_Data,
    output logic                     Out_Valid,
    input  logic                     Out_Ready,
    output logic                     Out_Full,
    output logic                     Out_Empty,
    output logic [$clog2(DEPTH):0]   Out_Count,
    output logic                     Overflow
);

    localparam int c_AW = $clog2(DEPTH);

    logic [31:0]     mem_q [DEPTH];
    logic [c_AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [c_AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [c_AW:0]   count_q, count_d;
    logic            ovf_q, ovf_d;

    logic            w_full;
    logic            w_empty;
    logic            w_pop;
    logic            w_push;

    assign w_full  = (count_q == DEPTH[c_AW:0]);
    assign w_empty = (count_q == '0);
    assign w_pop   = !w_empty && Out_Ready;
    // A full FIFO still accepts a word when the head leaves on the same edge.
    assign w_push  = OutPort && (!w_full || w_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        ovf_d    = ovf_q;
        if (w_push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (w_push && !w_pop) begin
            count_d = count_q + 1'b1;
        end else if (w_pop && !w_push) begin
            count_d = count_q - 1'b1;
        end
        if (OutPort && !w_push) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge Clock) begin
        if (!Clear) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
        end
    end

    // Storage is not reset; entries are only visible once counted.
    always_ff @(posedge Clock) begin
        if (Clear && w_push) begin
            mem_q[wr_ptr_q] <= BusMuxOut;
        end
    end

    assign Out_Data  = mem_q[rd_ptr_q];
    assign Out_Valid = !w_empty;
    assign Out_Full  = w_full;
    assign Out_Empty = w_empty;
    assign Out_Count = count_q;
    assign Overflow  = ovf_q;

endmodule

`default_nettype wire

// File: tb/tb_out_port_buffer.sv
// ============================================================================
// Module   : tb_out_port_buffer
// Brief    : Directed self-checking bench for out_port_buffer (DEPTH = 4).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_out_port_buffer;

    logic        Clock = 1'b0;
    logic        Clear;
    logic        OutPort;
    logic [31:0] BusMuxOut;
    logic [31:0] Out_Data;
    logic        Out_Valid;
    logic        Out_Ready;
    logic        Out_Full;
    logic        Out_Empty;
    logic [2:0]  Out_Count;
    logic        Overflow;

    int errors = 0;
    int checks = 0;

    out_port_buffer #(.DEPTH(4)) dut (
        .Clock     (Clock),
        .Clear     (Clear),
        .OutPort   (OutPort),
        .BusMuxOut (BusMuxOut),
        .Out_Data  (Out_Data),
        .Out_Valid (Out_Valid),
        .Out_Ready (Out_Ready),
        .Out_Full  (Out_Full),
        .Out_Empty (Out_Empty),
        .Out_Count (Out_Count),
        .Overflow  (Overflow)
    );

    always #5 Clock = ~Clock;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout required completion");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic push_word(input logic [31:0] w);
        OutPort   = 1'b1;
        BusMuxOut = w;
        tick();
        OutPort   = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_seq[4];

    initial begin
        int next_w;
        int got;
        int cyc;
        logic acc;
        logic popm;

        Clear = 1'b0; OutPort = 1'b0; Out_Ready = 1'b0; BusMuxOut = '0;
        tick(); tick();
        chk("rst_valid", Out_Valid, 0);
        chk("rst_empty", Out_Empty, 1);
        chk("rst_full",  Out_Full,  0);
        chk("rst_count", Out_Count, 0);
        chk("rst_ovf",   Overflow,  0);
        Clear = 1'b1;

        // Single word
        Out_Ready = 1'b1;
        push_word(32'h0000_00A5);
        chk("single_valid", Out_Valid, 1);
        chk("single_data",  Out_Data,  32'h0000_00A5);
        chk("single_count", Out_Count, 1);
        tick();
        chk("single_empty", Out_Empty, 1);
        chk("single_cnt0",  Out_Count, 0);
        tick();
        chk("ready_on_empty", Out_Count, 0);

        // Fill, then overflow from full
        Out_Ready = 1'b0;
        push_word(32'h11);
        chk("hold_head1", Out_Data, 32'h11);
        push_word(32'h22);
        push_word(32'h33);
        push_word(32'h44);
        chk("fill_full",  Out_Full,  1);
        chk("fill_count", Out_Count, 4);
        chk("fill_head",  Out_Data,  32'h11);
        chk("fill_ovf",   Overflow,  0);
        push_word(32'h55);
        chk("ovf_set",   Overflow,  1);
        chk("ovf_count", Out_Count, 4);
        chk("ovf_head",  Out_Data,  32'h11);
        exp_seq = '{32'h11, 32'h22, 32'h33, 32'h44};
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", Out_Valid, 1);
            chk("drain_data",  Out_Data,  exp_seq[i]);
            tick();
        end
        chk("drain_empty", Out_Empty, 1);
        chk("ovf_sticky",  Overflow,  1);
        Out_Ready = 1'b0;
        Clear = 1'b0;
        tick();
        Clear = 1'b1;
        chk("ovf_cleared", Overflow, 0);

        // Full with simultaneous push and pop
        push_word(32'h11);
        push_word(32'h22);
        push_word(32'h33);
        push_word(32'h44);
        Out_Ready = 1'b1;
        push_word(32'h66);
        Out_Ready = 1'b0;
        chk("pp_count", Out_Count, 4);
        chk("pp_full",  Out_Full,  1);
        chk("pp_ovf",   Overflow,  0);
        chk("pp_head",  Out_Data,  32'h22);
        exp_seq = '{32'h22, 32'h33, 32'h44, 32'h66};
        Out_Ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("pp_drain", Out_Data, exp_seq[i]);
            tick();
        end
        chk("pp_empty", Out_Empty, 1);
        Out_Ready = 1'b0;

        // Wrap with random Out_Ready, checked against a queue model
        next_w = 0;
        got    = 0;
        cyc    = 0;
        q.delete();
        while (got < 10 && cyc < 200) begin
            Out_Ready = 1'($urandom_range(0, 1));
            popm = (q.size() != 0) && Out_Ready;
            OutPort   = (next_w < 10) && ((q.size() < 4) || popm);
            BusMuxOut = 32'h100 + next_w;
            acc = OutPort;
            tick();
            if (popm) begin
                void'(q.pop_front());
                got++;
            end
            if (acc) begin
                q.push_back(32'h100 + next_w);
                next_w++;
            end
            cyc++;
            chk("wrap_count", Out_Count, q.size());
            if (q.size() != 0) begin
                chk("wrap_data", Out_Data, q[0]);
            end
        end
        OutPort = 1'b0;
        Out_Ready = 1'b0;
        chk("wrap_all_out", got, 10);
        chk("wrap_no_ovf",  Overflow, 0);

        // Reset mid-transfer
        push_word(32'h1);
        push_word(32'h2);
        push_word(32'h3);
        chk("mid_count3", Out_Count, 3);
        Clear = 1'b0;
        OutPort = 1'b1;
        BusMuxOut = 32'h77;
        tick();
        Clear = 1'b1;
        OutPort = 1'b0;
        chk("mid_count", Out_Count, 0);
        chk("mid_valid", Out_Valid, 0);
        chk("mid_ovf",   Overflow,  0);
        push_word(32'hBEEF);
        chk("mid_first", Out_Data,  32'hBEEF);
        chk("mid_cnt1",  Out_Count, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
